irq_arbiter: RTL and testbench
==============================

IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter: n, default 3, log2 of the number of interrupt sources (2**n lines).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: irq_in  input  2**n  raw interrupt request lines, already synchronous to clk.
REQ-005 Port: irq_en  input  2**n  per-source enable mask; 1 = eligible for arbitration.
REQ-006 Port: flush  input  1  clears all pending bits and withdraws any current offer.
REQ-007 Port: irq_valid  output  1  an interrupt id is being offered.
REQ-008 Port: irq_id  output  n  index of the offered source.
REQ-009 Port: irq_ready  input  1  consumer accepts the offered id this cycle.
REQ-010 Port: irq_pending  output  2**n  current pending register, unmasked, for CSR read-back.

Function
REQ-011 irq_in SHALL be registered each cycle into irq_prev; rise = irq_in & ~irq_prev.
REQ-012 A set rise bit SHALL set the matching pending bit at the same clock edge.
REQ-013 Arbitration SHALL select the highest set index of (pending & irq_en); lower indices lose.
REQ-014 FSM states: IDLE, OFFER.
REQ-015 IDLE -> OFFER when |(pending & irq_en): irq_id <= selected index, irq_valid <= 1.
REQ-016 IDLE with no eligible bit SHALL stay in IDLE with irq_valid = 0.
REQ-017 In OFFER, irq_id and irq_valid SHALL hold stable until irq_valid & irq_ready.
REQ-018 No pre-emption: a higher-index arrival during OFFER SHALL NOT change irq_id.
REQ-019 Clearing irq_en for the offered source during OFFER SHALL NOT withdraw the offer.
REQ-020 On accept (OFFER & irq_ready): pending[irq_id] <= 0, irq_valid <= 0, go to IDLE.
REQ-021 Accept coinciding with a new rise on the same source: set wins, pending bit stays 1.
REQ-022 Latency: irq_in rising sampled at edge k -> pending set after edge k -> irq_valid = 1 after edge k+1.
REQ-023 Back-to-back offers SHALL be separated by exactly one IDLE cycle with irq_valid = 0.
REQ-024 irq_ready while in IDLE SHALL have no effect.
REQ-025 Masked pending bits SHALL be retained and become eligible once irq_en is set.
REQ-026 flush SHALL clear pending, drop irq_valid and enter IDLE at the next edge.
REQ-027 flush SHALL override accept and any rise in the same cycle.
REQ-028 irq_pending SHALL equal the pending register with no extra delay.

Reset
REQ-029 reset SHALL force state IDLE, irq_valid = 0, irq_id = 0, pending = 0, irq_prev = 0.
REQ-030 reset SHALL take priority over flush, accept and rise.
REQ-031 A line held high through reset SHALL register as a rise on the first cycle after reset.

Structure
REQ-032 The state typedef SHALL be local to the module; no shared package is required.
REQ-033 Selection SHALL instantiate priority_encoder with the same n on (pending & irq_en).
REQ-034 All outputs SHALL be driven from registers except irq_pending, which is a direct register read-out.

Verification
REQ-035 n=3, irq_en=8'hFF; irq_in 8'h00 -> 8'h24 -> irq_valid = 1 with irq_id = 5 two edges later; accept -> pending = 8'h04; one idle cycle; then irq_id = 2.
REQ-036 Offer id 2 held with irq_ready = 0 for 5 cycles; irq_in[7] rises meanwhile -> irq_id stays 2 throughout; after accept, the next offer is irq_id = 7.
REQ-037 irq_en = 8'h0F, pending = 8'h80 -> irq_valid stays 0; set irq_en = 8'hFF -> irq_valid = 1, irq_id = 7 one edge later.
REQ-038 Accept id 3 in the same cycle irq_in[3] re-rises -> pending[3] = 1 after the edge; id 3 is re-offered after one idle cycle.
REQ-039 flush asserted during OFFER together with irq_ready and a rise on line 1 -> pending = 0, irq_valid = 0, state IDLE.
REQ-040 reset asserted mid-OFFER with irq_in = 8'h01 held high -> all outputs 0; irq_valid = 1, irq_id = 0 two edges after reset deasserts.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg
//   Shared constants for the interrupt arbiter slice.
//   irq_n_default : default log2 of the number of interrupt sources.
package irq_arbiter_pkg;

   localparam int irq_n_default = 3;

endpackage

// File: rtl/irq_arbiter_priority_encoder.sv
// priority_encoder
//   Combinational highest-index-wins encoder.
//   Ports:
//     req : 2**n request vector
//     idx : index of the highest set bit of req (0 when req is empty)
//     any : 1 when at least one bit of req is set
module priority_encoder #(
   parameter int n = 3
) (
   input  logic [2**n-1:0] req,
   output logic [n-1:0]    idx,
   output logic            any
);

   // Ascending scan: the last set bit seen is the highest index.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < 2**n; i++) begin
         if (req[i]) begin
            idx = i[n-1:0];
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter
//   Edge-detecting interrupt arbiter. Rising edges on irq_in latch pending
//   bits; the highest enabled pending index is offered to a consumer over a
//   valid/ready handshake.
//
//   Handshake: irq_valid/irq_id are registered outputs. Once irq_valid is
//   high, irq_id and irq_valid hold stable until a cycle in which
//   irq_valid & irq_ready are both high; that cycle is the transfer. irq_ready
//   while irq_valid is low has no effect.
//
//   Ports:
//     clk         : clock, rising edge
//     reset       : synchronous active-high reset
//     irq_in      : raw interrupt lines (synchronous to clk)
//     irq_en      : per-source enable mask
//     flush       : clears pending bits and withdraws any offer
//     irq_valid   : an id is being offered
//     irq_id      : offered source index
//     irq_ready   : consumer accepts the offered id
//     irq_pending : pending register read-out
//     fsm_state   : current FSM state (0 = IDLE, 1 = OFFER) for observation
module irq_arbiter
   import irq_arbiter_pkg::*;
#(
   parameter int n = irq_n_default
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [2**n-1:0] irq_in,
   input  logic [2**n-1:0] irq_en,
   input  logic            flush,
   output logic            irq_valid,
   output logic [n-1:0]    irq_id,
   input  logic            irq_ready,
   output logic [2**n-1:0] irq_pending,
   output logic [0:0]      fsm_state
);

   localparam int w = 2**n;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] OFFER = 1'b1;

   logic [0:0]   state;
   logic [w-1:0] irq_prev;
   logic [w-1:0] pending;
   logic [w-1:0] rise;
   logic [w-1:0] clr_mask;
   logic [w-1:0] pending_next;
   logic [n-1:0] sel_idx;
   logic         sel_any;
   logic         accept;

   priority_encoder #(
      .n (n)
   ) u_prio (
      .req (pending & irq_en),
      .idx (sel_idx),
      .any (sel_any)
   );

   assign rise   = irq_in & ~irq_prev;
   assign accept = (state == OFFER) && irq_ready;

   // Clear the accepted bit first, then OR in new rises so a re-rise on the
   // same line in the accept cycle keeps the bit set.
   always_comb begin
      clr_mask = '0;
      if (accept) begin
         clr_mask = {{(w-1){1'b0}}, 1'b1} << irq_id;
      end
      pending_next = (pending & ~clr_mask) | rise;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         irq_valid <= 1'b0;
         irq_id    <= '0;
         pending   <= '0;
         irq_prev  <= '0;
      end else begin
         irq_prev <= irq_in;
         if (flush) begin
            pending   <= '0;
            irq_valid <= 1'b0;
            state     <= IDLE;
         end else begin
            pending <= pending_next;
            case (state)
               IDLE: begin
                  // Arbitration uses the registered pending bits, so a rise
                  // is offered one edge after it is latched.
                  if (sel_any) begin
                     state     <= OFFER;
                     irq_valid <= 1'b1;
                     irq_id    <= sel_idx;
                  end
               end
               OFFER: begin
                  // No pre-emption and no withdrawal on mask change: only
                  // the handshake leaves OFFER.
                  if (irq_ready) begin
                     state     <= IDLE;
                     irq_valid <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign irq_pending = pending;
   assign fsm_state   = state;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter
//   Directed bench for irq_arbiter (n = 3). Expected ids are queued when an
//   offer is anticipated; a negedge monitor pops and compares on every
//   handshake. Register and timing expectations are checked inline.
module tb_irq_arbiter;

   localparam int n = 3;
   localparam int w = 2**n;

   logic         clk;
   logic         reset;
   logic [w-1:0] irq_in;
   logic [w-1:0] irq_en;
   logic         flush;
   logic         irq_valid;
   logic [n-1:0] irq_id;
   logic         irq_ready;
   logic [w-1:0] irq_pending;
   logic [0:0]   fsm_state;

   logic [n-1:0] exp_q[$];
   int           errors;
   int           checks;

   irq_arbiter #(
      .n (n)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .irq_in      (irq_in),
      .irq_en      (irq_en),
      .flush       (flush),
      .irq_valid   (irq_valid),
      .irq_id      (irq_id),
      .irq_ready   (irq_ready),
      .irq_pending (irq_pending),
      .fsm_state   (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [w-1:0] act,
                        input logic [w-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor: every handshake consumes one expected id
   always @(negedge clk) begin
      if (!reset && !flush && irq_valid === 1'b1 && irq_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept: got id %0d expected none", irq_id);
         end else begin
            logic [n-1:0] e;
            e = exp_q.pop_front();
            check("accept_id", w'(irq_id), w'(e));
         end
      end
   end

   initial begin
      errors    = 0;
      checks    = 0;
      reset     = 1'b1;
      irq_in    = '0;
      irq_en    = 8'hFF;
      flush     = 1'b0;
      irq_ready = 1'b0;
      tick();
      tick();
      check("reset_valid",   w'(irq_valid), 8'h00);
      check("reset_id",      w'(irq_id),    8'h00);
      check("reset_pending", irq_pending,   8'h00);
      check("reset_state",   w'(fsm_state), 8'h00);
      reset = 1'b0;
      tick();

      // basic arbitration and back-to-back offers
      irq_in = 8'h24;
      tick();
      check("t1_pending_set", irq_pending, 8'h24);
      check("t1_valid_lat1",  w'(irq_valid), 8'h00);
      tick();
      check("t1_valid",  w'(irq_valid), 8'h01);
      check("t1_id",     w'(irq_id),    8'h05);
      exp_q.push_back(3'd5);
      irq_ready = 1'b1;
      tick();
      check("t1_pending_after_accept", irq_pending, 8'h04);
      check("t1_idle_gap", w'(irq_valid), 8'h00);
      exp_q.push_back(3'd2);
      tick();
      check("t1_second_valid", w'(irq_valid), 8'h01);
      check("t1_second_id",    w'(irq_id),    8'h02);
      irq_in = 8'h00;
      tick();
      check("t1_drained", irq_pending, 8'h00);
      tick();
      check("idle_ready_no_effect", w'(irq_valid), 8'h00);
      irq_ready = 1'b0;

      // no pre-emption while offer is held
      irq_in = 8'h04;
      tick();
      tick();
      check("t2_id", w'(irq_id), 8'h02);
      exp_q.push_back(3'd2);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) irq_in = 8'h84;
         tick();
         check("t2_hold_valid", w'(irq_valid), 8'h01);
         check("t2_hold_id",    w'(irq_id),    8'h02);
      end
      check("t2_pending_both", irq_pending, 8'h84);
      exp_q.push_back(3'd7);
      irq_ready = 1'b1;
      tick();
      check("t2_pending_after", irq_pending, 8'h80);
      check("t2_gap", w'(irq_valid), 8'h00);
      tick();
      check("t2_next_id", w'(irq_id), 8'h07);
      tick();
      irq_ready = 1'b0;
      irq_in    = 8'h00;
      tick();

      // masked pending retained, offered once enabled
      irq_en = 8'h0F;
      irq_in = 8'h80;
      tick();
      check("t3_pending", irq_pending, 8'h80);
      tick();
      check("t3_masked_a", w'(irq_valid), 8'h00);
      tick();
      check("t3_masked_b", w'(irq_valid), 8'h00);
      irq_en = 8'hFF;
      tick();
      check("t3_valid", w'(irq_valid), 8'h01);
      check("t3_id",    w'(irq_id),    8'h07);
      exp_q.push_back(3'd7);
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      irq_in    = 8'h00;
      tick();

      // accept coinciding with a re-rise on the same line
      irq_in = 8'h08;
      tick();
      tick();
      check("t4_id", w'(irq_id), 8'h03);
      irq_in = 8'h00;
      tick();
      irq_in    = 8'h08;
      irq_ready = 1'b1;
      exp_q.push_back(3'd3);
      tick();
      check("t4_pending_kept", irq_pending, 8'h08);
      check("t4_gap", w'(irq_valid), 8'h00);
      exp_q.push_back(3'd3);
      tick();
      check("t4_reoffer_valid", w'(irq_valid), 8'h01);
      check("t4_reoffer_id",    w'(irq_id),    8'h03);
      tick();
      check("t4_cleared", irq_pending, 8'h00);
      irq_ready = 1'b0;
      irq_in    = 8'h00;
      tick();

      // flush overrides accept and rise
      irq_in = 8'h10;
      tick();
      tick();
      check("t5_id", w'(irq_id), 8'h04);
      irq_in    = 8'h12;
      irq_ready = 1'b1;
      flush     = 1'b1;
      tick();
      check("t5_pending", irq_pending,   8'h00);
      check("t5_valid",   w'(irq_valid), 8'h00);
      check("t5_state",   w'(fsm_state), 8'h00);
      flush     = 1'b0;
      irq_ready = 1'b0;
      tick();
      check("t5_no_late_rise", irq_pending, 8'h00);
      check("t5_still_idle",   w'(irq_valid), 8'h00);
      irq_in = 8'h00;
      tick();

      // reset mid-offer with line 0 held high
      irq_in = 8'h20;
      tick();
      tick();
      check("t6_id", w'(irq_id), 8'h05);
      irq_in = 8'h21;
      reset  = 1'b1;
      tick();
      check("t6_rst_valid",   w'(irq_valid), 8'h00);
      check("t6_rst_id",      w'(irq_id),    8'h00);
      check("t6_rst_pending", irq_pending,   8'h00);
      irq_in = 8'h01;
      tick();
      reset = 1'b0;
      tick();
      check("t6_post_pending", irq_pending,   8'h01);
      check("t6_post_valid0",  w'(irq_valid), 8'h00);
      tick();
      check("t6_post_valid1", w'(irq_valid), 8'h01);
      check("t6_post_id",     w'(irq_id),    8'h00);
      exp_q.push_back(3'd0);
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      tick();

      check("queue_drained", w'(exp_q.size()), 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
